audio_out_buffer: RTL and testbench
===================================

Name: audio_out_buffer

Overview:
Stereo sample FIFO between the moving-average filter output and the audio codec write port. It accepts one filtered left/right pair per in_valid pulse and drains to the codec whenever write_ready is high. A prefill state machine holds off draining until THRESH pairs are buffered. Overflow and underrun events are flagged and counted for debug on HEX/LEDs.

Parameters:
DEPTH, 8, FIFO depth in stereo pairs; power of two, at least 4
THRESH, 4, pairs required in FILL before draining starts; 1 to DEPTH
CNT_W, 16, width of the saturating event counters

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high; clock clk
in_valid  input  1  filtered pair present this cycle
in_left  input  24  signed left sample
in_right  input  24  signed right sample
in_ready  output  1  FIFO not full (level < DEPTH)
write_ready  input  1  codec can take a pair this cycle
write  output  1  pair on out_left/out_right consumed this cycle
out_left  output  24  signed head-of-FIFO left sample
out_right  output  24  signed head-of-FIFO right sample
level  output  $clog2(DEPTH)+1  pairs currently stored
overflow  output  1  sticky: a push was dropped
underrun  output  1  sticky: drained to empty while running
drop_count  output  CNT_W  dropped pushes, saturating
underrun_count  output  CNT_W  underrun events, saturating

Behaviour:
- Reset: level=0, pointers=0, state=FILL, write=0, overflow=0, underrun=0, both counters=0. out_left/out_right read as 0 while empty. Memory contents are don't-care.
- push = in_valid && (level < DEPTH). Acceptance depends only on registered level, not on a same-cycle pop, so a push to a full FIFO is dropped even if a pop occurs that cycle.
- Dropped push (in_valid while full): sets overflow; drop_count += 1, saturating at all-ones.
- A pair pushed at edge k is visible at the head after edge k.
- pop = write = (state==RUN) && write_ready && (level != 0). write is combinational from registered state/level plus write_ready. out_left/out_right are combinational show-ahead from the head entry, and are valid whenever write=1.
- Simultaneous push and pop: level unchanged, and both pointers advance. Pointers wrap modulo DEPTH.
- FSM:
  - FILL: write held 0. If level >= THRESH (registered), the next state is RUN.
  - RUN: normal drain. If level==0 and write_ready==1, the next state is FILL, underrun is set, and underrun_count += 1 (saturating). This counts once per event, not once per cycle.
  - RUN with level==0 and write_ready==0 stays RUN, with no underrun.
- Arithmetic: samples pass through bit-exact; no scaling and no sign handling.
- Sticky flags clear only on reset.
- Reset mid-operation: all state returns to reset values on the next edge. Any stored pairs are discarded.

Decomposition:
- audio_pkg holds:
  - sample_t (logic signed [23:0])
  - stereo_t (packed struct of left/right sample_t)
  - buf_state_t enum {FILL, RUN}
- Sub-module audio_fifo_mem: DEPTH x stereo_t register file.
  - Synchronous write on push at wr_ptr.
  - Combinational read at rd_ptr.
  - Pointer/level logic and the FSM stay in audio_out_buffer.

Test Plan:
1. Reset asserted 2 cycles with in_valid=1 and write_ready=1 -> level=0, write=0, out_left=out_right=0, flags and counters 0, in_ready=1.
2. write_ready=1; push (4,16), (-32,-13), (-12,16), (-3,13) on consecutive edges.
   - write stays 0 through the 4th push edge.
   - FSM enters RUN one edge later; write=1 from then on.
   - Pairs drain in order: out_left = 4, -32, -12, -3 and out_right = 16, -13, 16, 13.
3. write_ready=0; push 9 distinct pairs.
   - After 8 pushes: level=8, in_ready=0.
   - 9th push is dropped: overflow=1, drop_count=1, level stays 8.
   - Then write_ready=1: exactly the first 8 pairs drain in order.
4. In RUN at level=5, hold in_valid=1 and write_ready=1 for 10 cycles -> level stays 5 and write=1 every cycle; the output sequence equals the input sequence delayed by 5 pairs.
5. In RUN, stop pushing with write_ready=1 until level reaches 0.
   - underrun=1 and underrun_count=1; FSM returns to FILL.
   - Holding empty 5 more cycles leaves the count at 1.
   - 3 new pushes give write=0; the 4th restarts draining.
6. Reset mid-stream at level=6 with overflow=1 -> next edge: level=0, write=0, FILL, all flags/counters 0. Subsequent pushes behave as in scenario 2.

Source files
------------

// File: rtl/audio_pkg.sv
// Shared sample and buffer-state types for the audio output path.
package audio_pkg;

    typedef logic signed [23:0] sample_t;

    typedef struct packed {
        sample_t left;
        sample_t right;
    } stereo_t;

    typedef enum logic {
        FILL = 1'b0,
        RUN  = 1'b1
    } buf_state_t;

endpackage

// File: rtl/audio_fifo_mem.sv
// DEPTH x stereo pair register file: synchronous write, combinational show-ahead read.
module audio_fifo_mem
    import audio_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_ptr,
    input  stereo_t       wr_dat,
    input  logic [AW-1:0] rd_ptr,
    output stereo_t       rd_dat
);

    stereo_t mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr] <= wr_dat;
        end
    end

    assign rd_dat = mem_q[rd_ptr];

endmodule

// File: rtl/audio_out_buffer.sv
// Stereo FIFO to the codec with a prefill gate; pushes land at the head one edge later,
// full FIFO drops pushes (flagged/counted), draining to empty while running counts an underrun.
module audio_out_buffer
    import audio_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int THRESH = 4,
    parameter int CNT_W  = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    input  logic [23:0]            in_left,
    input  logic [23:0]            in_right,
    output logic                   in_ready,
    input  logic                   write_ready,
    output logic                   write,
    output logic [23:0]            out_left,
    output logic [23:0]            out_right,
    output logic [$clog2(DEPTH):0] level,
    output logic                   overflow,
    output logic                   underrun,
    output logic [CNT_W-1:0]       drop_count,
    output logic [CNT_W-1:0]       underrun_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    buf_state_t       state_q, state_d;
    logic             overflow_q, overflow_d, underrun_q, underrun_d;
    logic [CNT_W-1:0] drop_count_q, drop_count_d, underrun_count_q, underrun_count_d;

    logic    push, drop, pop, underrun_ev, empty;
    stereo_t wr_dat, head;

    // Acceptance looks only at the registered level, so a same-cycle pop never frees a slot.
    assign empty       = (level_q == '0);
    assign push        = in_valid && (level_q < LW'(DEPTH));
    assign drop        = in_valid && !push;
    assign pop         = (state_q == RUN) && write_ready && !empty;
    assign underrun_ev = (state_q == RUN) && write_ready && empty;

    assign wr_dat = '{left: sample_t'(in_left), right: sample_t'(in_right)};

    audio_fifo_mem #(.DEPTH(DEPTH), .AW(AW)) u_mem (
        .clk    (clk),
        .wr_en  (push),
        .wr_ptr (wr_ptr_q),
        .wr_dat (wr_dat),
        .rd_ptr (rd_ptr_q),
        .rd_dat (head)
    );

    always_comb begin
        wr_ptr_d         = wr_ptr_q;
        rd_ptr_d         = rd_ptr_q;
        level_d          = level_q;
        state_d          = state_q;
        overflow_d       = overflow_q;
        underrun_d       = underrun_q;
        drop_count_d     = drop_count_q;
        underrun_count_d = underrun_count_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        level_d = level_q + LW'(push) - LW'(pop);

        if (drop) begin
            overflow_d = 1'b1;
            if (drop_count_q != '1) begin
                drop_count_d = drop_count_q + CNT_W'(1);
            end
        end

        case (state_q)
            FILL: begin
                if (level_q >= LW'(THRESH)) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                // Leaving RUN on the event makes the count once-per-underrun.
                if (underrun_ev) begin
                    state_d    = FILL;
                    underrun_d = 1'b1;
                    if (underrun_count_q != '1) begin
                        underrun_count_d = underrun_count_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q         <= '0;
            rd_ptr_q         <= '0;
            level_q          <= '0;
            state_q          <= FILL;
            overflow_q       <= 1'b0;
            underrun_q       <= 1'b0;
            drop_count_q     <= '0;
            underrun_count_q <= '0;
        end else begin
            wr_ptr_q         <= wr_ptr_d;
            rd_ptr_q         <= rd_ptr_d;
            level_q          <= level_d;
            state_q          <= state_d;
            overflow_q       <= overflow_d;
            underrun_q       <= underrun_d;
            drop_count_q     <= drop_count_d;
            underrun_count_q <= underrun_count_d;
        end
    end

    assign in_ready       = (level_q < LW'(DEPTH));
    assign write          = pop;
    assign out_left       = empty ? '0 : head.left;
    assign out_right      = empty ? '0 : head.right;
    assign level          = level_q;
    assign overflow       = overflow_q;
    assign underrun       = underrun_q;
    assign drop_count     = drop_count_q;
    assign underrun_count = underrun_count_q;

endmodule

// File: tb/tb_audio_out_buffer.sv
// Scoreboard bench for audio_out_buffer: accepted pushes queue expected pairs, writes pop them.
module tb_audio_out_buffer;
    import audio_pkg::*;

    localparam int DEPTH  = 8;
    localparam int THRESH = 4;
    localparam int CNT_W  = 16;

    logic             clk = 1'b0;
    logic             reset, in_valid, write_ready;
    logic [23:0]      in_left, in_right;
    logic             in_ready, write, overflow, underrun;
    logic [23:0]      out_left, out_right;
    logic [3:0]       level;
    logic [CNT_W-1:0] drop_count, underrun_count;

    audio_out_buffer #(.DEPTH(DEPTH), .THRESH(THRESH), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_left(in_left),
        .in_right(in_right), .in_ready(in_ready), .write_ready(write_ready),
        .write(write), .out_left(out_left), .out_right(out_right), .level(level),
        .overflow(overflow), .underrun(underrun), .drop_count(drop_count),
        .underrun_count(underrun_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    stereo_t          sb[$];
    bit               m_run, m_ovf, m_und;
    logic [CNT_W-1:0] m_drop, m_undc;
    int               m_pops;

    // One clock cycle: drive inputs, check every output against the model, advance the model.
    task automatic cycle(input logic vld, input logic [23:0] l, input logic [23:0] r, input logic wr);
        logic    exp_wr;
        bit      push, next_run;
        stereo_t p;
        in_valid = vld; in_left = l; in_right = r; write_ready = wr;
        #1;
        exp_wr = m_run && wr && (sb.size() != 0);
        n_checks++;
        if (write !== exp_wr) begin
            n_fail++; $display("FAIL write: got %b expected %b at %0t", write, exp_wr, $time);
        end
        if (sb.size() != 0) begin
            p = sb[0];
            n_checks++;
            if (out_left !== 24'(p.left) || out_right !== 24'(p.right)) begin
                n_fail++;
                $display("FAIL head_data: got (%0d,%0d) expected (%0d,%0d) at %0t",
                         $signed(out_left), $signed(out_right), p.left, p.right, $time);
            end
        end else begin
            n_checks++;
            if (out_left !== 24'd0 || out_right !== 24'd0) begin
                n_fail++; $display("FAIL empty_out: got (%h,%h) expected 0 at %0t", out_left, out_right, $time);
            end
        end
        n_checks++;
        if (level !== 4'(sb.size()) || in_ready !== (sb.size() < DEPTH)) begin
            n_fail++; $display("FAIL level: got %0d/rdy %b expected %0d at %0t", level, in_ready, sb.size(), $time);
        end
        n_checks++;
        if (overflow !== m_ovf || underrun !== m_und || drop_count !== m_drop || underrun_count !== m_undc) begin
            n_fail++;
            $display("FAIL flags: got ovf %b und %b drop %0d undc %0d expected %b %b %0d %0d at %0t",
                     overflow, underrun, drop_count, underrun_count, m_ovf, m_und, m_drop, m_undc, $time);
        end
        push = vld && (sb.size() < DEPTH);
        if (!m_run) begin
            next_run = (sb.size() >= THRESH);
        end else if (sb.size() == 0 && wr) begin
            next_run = 1'b0;
            m_und    = 1'b1;
            if (m_undc != '1) m_undc++;
        end else begin
            next_run = 1'b1;
        end
        if (vld && !push) begin
            m_ovf = 1'b1;
            if (m_drop != '1) m_drop++;
        end
        if (exp_wr) begin
            void'(sb.pop_front());
            m_pops++;
        end
        if (push) sb.push_back('{left: sample_t'(l), right: sample_t'(r)});
        m_run = next_run;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1; in_valid = 1'b1; write_ready = 1'b1;
        in_left = 24'h123456; in_right = 24'h654321;
        repeat (n) @(posedge clk);
        @(negedge clk);
        reset = 1'b0; in_valid = 1'b0;
        sb.delete();
        m_run = 0; m_ovf = 0; m_und = 0; m_drop = '0; m_undc = '0; m_pops = 0;
    endtask

    task automatic test_reset();
        do_reset(2);
        write_ready = 1'b1;
        #1;
        n_checks++;
        if (level !== 4'd0 || write !== 1'b0 || out_left !== 24'd0 || out_right !== 24'd0 ||
            overflow !== 1'b0 || underrun !== 1'b0 || drop_count !== '0 ||
            underrun_count !== '0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_state: got lvl %0d wr %b out %h/%h ovf %b und %b drop %0d undc %0d rdy %b expected all zero, rdy 1",
                     level, write, out_left, out_right, overflow, underrun, drop_count, underrun_count, in_ready);
        end
    endtask

    task automatic push_four();
        int lv[4] = '{4, -32, -12, -3};
        int rv[4] = '{16, -13, 16, 13};
        for (int i = 0; i < 4; i++) cycle(1'b1, 24'(lv[i]), 24'(rv[i]), 1'b1);
        n_checks++;
        if (write !== 1'b0) begin
            n_fail++; $display("FAIL prefill_hold: got write %b expected 0", write);
        end
        for (int i = 0; i < 5; i++) cycle(1'b0, 24'd0, 24'd0, 1'b1);
        n_checks++;
        if (m_pops != 4) begin
            n_fail++; $display("FAIL prefill_drain: got %0d pops expected 4", m_pops);
        end
    endtask

    task automatic test_prefill();
        do_reset(1);
        push_four();
    endtask

    task automatic test_overflow();
        do_reset(1);
        for (int i = 0; i < 9; i++) cycle(1'b1, 24'(100 + i), 24'(-200 - i), 1'b0);
        n_checks++;
        if (level !== 4'd8 || in_ready !== 1'b0 || overflow !== 1'b1 || drop_count !== 16'd1) begin
            n_fail++;
            $display("FAIL overflow: got lvl %0d rdy %b ovf %b drop %0d expected 8 0 1 1",
                     level, in_ready, overflow, drop_count);
        end
        for (int i = 0; i < 10; i++) cycle(1'b0, 24'd0, 24'd0, 1'b1);
        n_checks++;
        if (m_pops != 8) begin
            n_fail++; $display("FAIL overflow_drain: got %0d pops expected 8", m_pops);
        end
    endtask

    task automatic test_back_to_back();
        do_reset(1);
        for (int i = 0; i < 5; i++) cycle(1'b1, 24'($urandom), 24'($urandom), 1'b0);
        cycle(1'b0, 24'd0, 24'd0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            n_checks++;
            if (level !== 4'd5) begin
                n_fail++; $display("FAIL steady_level: got %0d expected 5", level);
            end
            cycle(1'b1, 24'($urandom), 24'($urandom), 1'b1);
        end
        n_checks++;
        if (m_pops != 10) begin
            n_fail++; $display("FAIL steady_writes: got %0d writes expected 10", m_pops);
        end
    endtask

    task automatic test_underrun();
        int guard = 0;
        while (sb.size() != 0 && guard < 20) begin
            cycle(1'b0, 24'd0, 24'd0, 1'b1);
            guard++;
        end
        n_checks++;
        if (guard >= 20) begin
            n_fail++; $display("FAIL drain_timeout: level %0d never reached 0", level);
        end
        for (int i = 0; i < 6; i++) cycle(1'b0, 24'd0, 24'd0, 1'b1);
        n_checks++;
        if (underrun !== 1'b1 || underrun_count !== 16'd1) begin
            n_fail++; $display("FAIL underrun_once: got und %b count %0d expected 1 1", underrun, underrun_count);
        end
        for (int i = 0; i < 3; i++) cycle(1'b1, 24'(7 * i), 24'(-7 * i), 1'b1);
        cycle(1'b1, 24'h7fffff, 24'h800000, 1'b1);
        cycle(1'b0, 24'd0, 24'd0, 1'b1);
        n_checks++;
        if (m_pops < 1 || write !== 1'b1) begin
            n_fail++; $display("FAIL restart: got write %b expected 1", write);
        end
    endtask

    task automatic test_mid_reset();
        do_reset(1);
        for (int i = 0; i < 9; i++) cycle(1'b1, 24'($urandom), 24'($urandom), 1'b0);
        cycle(1'b0, 24'd0, 24'd0, 1'b1);
        cycle(1'b0, 24'd0, 24'd0, 1'b1);
        n_checks++;
        if (level !== 4'd6 || overflow !== 1'b1) begin
            n_fail++; $display("FAIL pre_reset: got lvl %0d ovf %b expected 6 1", level, overflow);
        end
        do_reset(1);
        write_ready = 1'b1;
        #1;
        n_checks++;
        if (level !== 4'd0 || write !== 1'b0 || overflow !== 1'b0 || drop_count !== '0) begin
            n_fail++;
            $display("FAIL mid_reset: got lvl %0d wr %b ovf %b drop %0d expected 0 0 0 0",
                     level, write, overflow, drop_count);
        end
        push_four();
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; write_ready = 1'b0;
        in_left = '0; in_right = '0;
        @(negedge clk);
        test_reset();
        test_prefill();
        test_overflow();
        test_back_to_back();
        test_underrun();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
